// File: rtl/bus_master_pkg.sv
// Shared definitions for the CPU bus master and its neighbours (io_manager, CPU).
// Holds the master FSM state encoding, the memory-mapped IO addresses and the
// wait counter width. Nothing here generates hardware on its own.
package bus_master_pkg;

  // Master sequencing states; binary encoded.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Memory-mapped IO addresses decoded by io_manager (the master passes them through).
  localparam logic [15:0] IO_LED_R   = 16'hFFFF;
  localparam logic [15:0] IO_LED_G   = 16'hFFFE;
  localparam logic [15:0] IO_BUTTONS = 16'hFFFD;

  // Wait counter width; covers WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // True when an address targets one of the IO registers rather than SRAM.
  function automatic logic is_io_addr(input logic [15:0] a);
    return (a == IO_LED_R) || (a == IO_LED_G) || (a == IO_BUTTONS);
  endfunction

endpackage

// File: rtl/bus_master_xcvr.sv
// Tri-state transceiver for the shared data bus.
// Ports:
//   drive - 1 = put dout on the bus, 0 = release the bus (high impedance)
//   dout  - value driven when drive is high
//   din   - current bus value, always visible to the master
//   bus   - shared bidirectional data lines
module bus_master_xcvr (
  input  logic        drive,
  input  logic [15:0] dout,
  output logic [15:0] din,
  inout  wire  [15:0] bus
);

  assign bus = drive ? dout : 16'bz;
  assign din = bus;

endmodule

// File: rtl/bus_master.sv
// CPU-side bus master: turns a one-cycle-sampled request from the core into a
// SETUP / ACCESS(WAIT_CYCLES) / HOLD bus cycle on a shared tri-state data bus.
// Ports:
//   clk, reset       - clock; asynchronous active-low reset
//   req, we          - request and direction (1 = write), sampled only in IDLE
//   addr, wdata      - address and write data, latched on the accept edge
//   rdata            - read data, captured on the edge entering HOLD
//   busy             - high from the accept edge until back in IDLE
//   done             - one-cycle pulse during HOLD
//   dir_out          - address towards io_manager / SRAM (0 while idle)
//   oe               - write strobe; also the data bus output enable
//   Datos            - shared bidirectional data bus
//   fsm_state        - current FSM state, for observation only
// Handshake: the core raises req and holds it with stable we/addr/wdata until
// busy rises; a request seen while busy is neither accepted nor remembered.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] dir_out,
  output logic        oe,
  inout  wire  [15:0] Datos,
  output state_t      fsm_state
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               load;
  logic               cap;

  logic               we_q, we_n;
  logic [15:0]        addr_q, addr_n;
  logic [15:0]        wdata_q;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               oe_q, oe_d;
  logic [15:0]        dir_q, dir_d;
  logic [15:0]        rdata_q;
  logic [15:0]        bus_in;

  // Next-state logic. The counter is loaded on the accept edge so it already
  // holds WAIT_CYCLES-1 during SETUP; ACCESS then runs until it reads zero,
  // which gives exactly WAIT_CYCLES ACCESS cycles.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          load    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          state_d = S_HOLD;
          cap     = ~we_q;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so every bus
  // control (including the data bus enable) comes straight from a flop.
  always_comb begin
    we_n   = load ? we   : we_q;
    addr_n = load ? addr : addr_q;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_HOLD);
    oe_d   = we_n && ((state_d == S_SETUP) || (state_d == S_ACCESS));
    dir_d  = (state_d == S_IDLE) ? 16'h0000 : addr_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
      dir_q   <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      if (load) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      busy_q <= busy_d;
      done_q <= done_d;
      oe_q   <= oe_d;
      dir_q  <= dir_d;
      if (cap) begin
        rdata_q <= bus_in;
      end
    end
  end

  // The write strobe doubles as the bus drive enable: it is high only in
  // SETUP/ACCESS of a write, so the bus is already released in HOLD before
  // any responder of a following read can drive it.
  bus_master_xcvr u_xcvr (
    .drive (oe_q),
    .dout  (wdata_q),
    .din   (bus_in),
    .bus   (Datos)
  );

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign oe        = oe_q;
  assign dir_out   = dir_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: unit 0 uses WAIT_CYCLES=2, unit 1 uses WAIT_CYCLES=1.
// Each unit sits on its own bus with a small io_manager/SRAM model.
module tb_bus_master;
  import bus_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT hookup ----------------
  logic        req_s[2];
  logic        we_s[2];
  logic [15:0] addr_s[2];
  logic [15:0] wdata_s[2];
  logic [15:0] rdata_v[2];
  logic        busy_v[2];
  logic        done_v[2];
  logic [15:0] dir_v[2];
  logic        oe_v[2];
  logic [15:0] datos_v[2];
  state_t      st_v[2];
  wire  [15:0] datos0;
  wire  [15:0] datos1;

  bus_master #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .dir_out(dir_v[0]), .oe(oe_v[0]), .Datos(datos0), .fsm_state(st_v[0])
  );

  bus_master #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .dir_out(dir_v[1]), .oe(oe_v[1]), .Datos(datos1), .fsm_state(st_v[1])
  );

  assign datos_v[0] = datos0;
  assign datos_v[1] = datos1;

  // ---------------- bus / io_manager model ----------------
  logic [3:0]  buttons = 4'b1010;
  logic [9:0]  led_r[2];
  logic [7:0]  led_g[2];
  logic [15:0] sram[2][256];
  bit          written[2][256];
  logic [15:0] wr_buf[2];
  logic        pend[2];

  // Unwritten SRAM locations read back as addr ^ 16'hBEEF.
  function automatic logic [15:0] rsp_val(input int g, input logic [15:0] a);
    if (a == 16'hFFFD)           return {12'h000, buttons};
    else if (a == 16'hFFFF)      return {6'h00, led_r[g]};
    else if (a == 16'hFFFE)      return {8'h00, led_g[g]};
    else if (written[g][a[7:0]]) return sram[g][a[7:0]];
    else                         return a ^ 16'hBEEF;
  endfunction

  // Responder drives the bus whenever the master is busy but not writing.
  assign datos0 = (busy_v[0] && !oe_v[0]) ? rsp_val(0, dir_v[0]) : 16'bz;
  assign datos1 = (busy_v[1] && !oe_v[1]) ? rsp_val(1, dir_v[1]) : 16'bz;

  // Write data is sampled while oe is high and committed at the end of HOLD.
  for (genvar g = 0; g < 2; g++) begin : g_bus
    always @(posedge clk) begin
      if (!busy_v[g]) begin
        pend[g] <= 1'b0;
      end else if (oe_v[g]) begin
        wr_buf[g] <= datos_v[g];
        pend[g]   <= 1'b1;
      end else if (done_v[g] && pend[g]) begin
        pend[g] <= 1'b0;
        if (dir_v[g] == 16'hFFFF)      led_r[g] <= wr_buf[g][9:0];
        else if (dir_v[g] == 16'hFFFE) led_g[g] <= wr_buf[g][7:0];
        else if (dir_v[g] != 16'hFFFD) begin
          sram[g][dir_v[g][7:0]]    <= wr_buf[g];
          written[g][dir_v[g][7:0]] <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt[2] = '{0, 0};
  logic [16:0] exp_q0[$];   // {is_read, expected data}
  logic [16:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_item(input int u, input logic [16:0] e);
    if (e[16]) check($sformatf("rdata_u%0d", u), {16'h0, rdata_v[u]}, {16'h0, e[15:0]});
    else       check($sformatf("wdata_u%0d", u), {16'h0, wr_buf[u]}, {16'h0, e[15:0]});
  endtask

  always @(negedge clk) begin
    if (done_v[0]) begin
      done_cnt[0] <= done_cnt[0] + 1;
      if (exp_q0.size() == 0) check("unexpected_done_u0", 32'd1, 32'd0);
      else check_item(0, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (done_v[1]) begin
      done_cnt[1] <= done_cnt[1] + 1;
      if (exp_q1.size() == 0) check("unexpected_done_u1", 32'd1, 32'd0);
      else check_item(1, exp_q1.pop_front());
    end
  end

  // ---------------- driver ----------------
  function automatic int wc(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic drive_req(input int u, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
    req_s[u]   = r;
    we_s[u]    = w;
    addr_s[u]  = a;
    wdata_s[u] = d;
  endtask

  // Called at a falling edge with the unit idle (or in its IDLE cycle with req
  // held). Returns the number of rising edges until the accept edge.
  task automatic txn(input int u, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd,
                     input bit hold_req, output int gap);
    int  n, k, oe_n;
    bit  acc, seen;
    logic pre;
    drive_req(u, 1'b1, w, a, d);
    acc = 0; n = 0;
    pre = busy_v[u];
    while (!acc && n < 40) begin
      @(posedge clk); #1; n++;
      if (!pre && busy_v[u]) acc = 1;
      else begin @(negedge clk); pre = busy_v[u]; end
    end
    gap = n;
    check($sformatf("accept_u%0d", u), {31'h0, acc}, 32'd1);
    if (!acc) return;
    if (!hold_req) req_s[u] = 1'b0;
    if (u == 0) exp_q0.push_back({~w, w ? d : exp_rd});
    else        exp_q1.push_back({~w, w ? d : exp_rd});
    // Falling edge k lies in the cycle after accept edge + (k-1): SETUP is k=1,
    // so done (HOLD) must first appear at k = WAIT_CYCLES+2.
    k = 0; oe_n = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk); k++;
      check($sformatf("dir_out_u%0d", u), {16'h0, dir_v[u]}, {16'h0, a});
      if (oe_v[u]) begin
        oe_n++;
        check($sformatf("datos_drive_u%0d", u), {16'h0, datos_v[u]}, {16'h0, d});
      end
      if (done_v[u]) seen = 1;
    end
    check($sformatf("done_latency_u%0d", u), k, wc(u) + 2);
    check($sformatf("oe_cycles_u%0d", u), oe_n, w ? wc(u) + 1 : 0);
    @(negedge clk);
    check($sformatf("idle_busy_u%0d", u), {31'h0, busy_v[u]}, 32'd0);
    check($sformatf("idle_done_u%0d", u), {31'h0, done_v[u]}, 32'd0);
    check($sformatf("idle_oe_u%0d", u), {31'h0, oe_v[u]}, 32'd0);
    check($sformatf("idle_dir_u%0d", u), {16'h0, dir_v[u]}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int g0, g1, dc_before, t;
  logic [9:0] led_before;

  initial begin
    for (int i = 0; i < 2; i++) drive_req(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy_v[0]}, 32'd0);
    check("rst_done", {31'h0, done_v[0]}, 32'd0);
    check("rst_oe", {31'h0, oe_v[0]}, 32'd0);
    check("rst_dir", {16'h0, dir_v[0]}, 32'd0);
    check("rst_rdata", {16'h0, rdata_v[0]}, 32'd0);
    check("rst_busy_u1", {31'h0, busy_v[1]}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write red LEDs.
    txn(0, 1'b1, 16'hFFFF, 16'h03FF, 16'h0000, 0, g0);
    check("led_r", {22'h0, led_r[0]}, 32'h3FF);

    // Read buttons while pulsing req mid-transaction: the pulse must be ignored.
    dc_before = done_cnt[0];
    fork
      txn(0, 1'b0, 16'hFFFD, 16'h0000, 16'h000A, 0, g0);
      begin
        t = 0;
        while (!busy_v[0] && t < 20) begin @(negedge clk); t++; end
        @(negedge clk); req_s[0] = 1'b1;
        @(negedge clk); req_s[0] = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    check("busy_pulse_done_count", done_cnt[0] - dc_before, 32'd1);
    check("busy_pulse_not_queued", {31'h0, busy_v[0]}, 32'd0);

    // req held high: write green LEDs then read them back with one IDLE cycle between.
    txn(0, 1'b1, 16'hFFFE, 16'h00A5, 16'h0000, 1, g0);
    txn(0, 1'b0, 16'hFFFE, 16'h0000, 16'h00A5, 0, g1);
    check("b2b_gap", g1, 32'd1);

    // Unit with WAIT_CYCLES=1: SRAM read, write, read back.
    txn(1, 1'b0, 16'h0010, 16'h0000, 16'hBEFF, 0, g0);
    txn(1, 1'b1, 16'h0011, 16'h1234, 16'h0000, 0, g0);
    txn(1, 1'b0, 16'h0011, 16'h0000, 16'h1234, 0, g0);

    // Reset during ACCESS of a write.
    led_before = led_r[0];
    dc_before  = done_cnt[0];
    drive_req(0, 1'b1, 1'b1, 16'hFFFF, 16'h0155);
    t = 0;
    while (!busy_v[0] && t < 20) begin @(posedge clk); #1; t++; end
    check("rst_test_accept", {31'h0, busy_v[0]}, 32'd1);
    req_s[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_test_in_access", {30'h0, st_v[0]}, {30'h0, S_ACCESS});
    #2 reset = 1'b0;
    #1;
    check("async_busy", {31'h0, busy_v[0]}, 32'd0);
    check("async_oe", {31'h0, oe_v[0]}, 32'd0);
    check("async_done", {31'h0, done_v[0]}, 32'd0);
    check("async_dir", {16'h0, dir_v[0]}, 32'd0);
    check("async_rdata", {16'h0, rdata_v[0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_done", done_cnt[0] - dc_before, 32'd0);
    check("rst_led_unchanged", {22'h0, led_r[0]}, {22'h0, led_before});
    check("rst_idle", {31'h0, busy_v[0]}, 32'd0);

    // LEDs still readable after the abandoned write.
    txn(0, 1'b0, 16'hFFFF, 16'h0000, 16'h03FF, 0, g0);

    repeat (2) @(negedge clk);
    check("sb_empty_u0", exp_q0.size(), 32'd0);
    check("sb_empty_u1", exp_q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of ACCESS cycles per transaction; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low (port named reset).
REQ-004 req  input  1  transaction request from the CPU core; sampled only in IDLE.
REQ-005 we  input  1  1 = write, 0 = read; sampled with req.
REQ-006 addr  input  16  bus address; sampled with req.
REQ-007 wdata  input  16  write data; sampled with req.
REQ-008 rdata  output  16  read data; registered, valid from done until next read completes.
REQ-009 busy  output  1  high from accept edge until return to IDLE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 dir_out  output  16  address to the io manager / SRAM address path.
REQ-012 oe  output  1  bus write strobe: 1 = master writes, 0 = master reads or idle.
REQ-013 Datos  inout  16  shared bidirectional data bus.

Function
REQ-014 FSM states: IDLE, SETUP, ACCESS, HOLD; registered, one-hot or binary at implementer's choice.
REQ-015 IDLE: req=1 at rising edge latches we/addr/wdata, sets busy, moves to SETUP; req=0 stays IDLE.
REQ-016 SETUP lasts exactly 1 cycle: dir_out = latched addr, oe = latched we, wait counter loaded with WAIT_CYCLES-1.
REQ-017 ACCESS lasts exactly WAIT_CYCLES cycles: dir_out and oe held, counter decrements each cycle, exit to HOLD at edge where counter = 0.
REQ-018 HOLD lasts exactly 1 cycle: dir_out held, oe = 0, Datos released, done = 1; next edge -> IDLE, busy cleared.
REQ-019 Write: Datos driven with latched wdata throughout SETUP and ACCESS only; high-impedance in all other states.
REQ-020 Read: Datos never driven by master; rdata captured from Datos on the edge leaving ACCESS (entering HOLD).
REQ-021 Latency: done high during the cycle beginning WAIT_CYCLES+2 edges after the accept edge; next accept possible at the edge ending HOLD+1 (IDLE must be occupied at least one cycle).
REQ-022 req asserted while busy is ignored and not queued; CPU must hold req until it is accepted.
REQ-023 req held continuously high yields back-to-back transactions separated by exactly one IDLE cycle.
REQ-024 IDLE outputs: dir_out = 16'h0000, oe = 0, Datos high-impedance, done = 0, busy = 0.
REQ-025 Address decoding is not done here; IO addresses 16'hFFFF (red LEDs), 16'hFFFE (green LEDs), 16'hFFFD (buttons) pass through unchanged.
REQ-026 A write followed immediately by a read never has both sides driving Datos: master releases in HOLD before the responder drives.

Reset
REQ-027 reset low forces, asynchronously: state IDLE, busy 0, done 0, oe 0, dir_out 16'h0000, rdata 16'h0000, Datos high-impedance, counter 0.
REQ-028 Reset mid-transaction abandons it without a done pulse; latched request discarded.
REQ-029 After reset release, first accept occurs no earlier than the first rising edge with reset high.

Structure
REQ-030 State encodings and the IO address constants (FFFF, FFFE, FFFD) live in the shared include file used by io_manager and the CPU.
REQ-031 Tri-state drive of Datos uses the existing transceiver sub-module; no other sub-modules.
REQ-032 Datos output-enable and write data are registered, never combinational from req.

Verification
REQ-033 WAIT_CYCLES=2, write addr 16'hFFFF wdata 16'h03FF -> oe high 3 cycles, Datos=16'h03FF in SETUP/ACCESS, done at accept+4 edges, LED_R = 10'h3FF afterwards.
REQ-034 Read addr 16'hFFFD with buttons=4'b1010 -> rdata = 16'h000A with done, Datos never driven by master.
REQ-035 req held high for write FFFE/16'h00A5 then read FFFE -> exactly one IDLE cycle between, rdata = 16'h00A5, no bus contention (no X on Datos).
REQ-036 req pulsed while busy=1 -> ignored, exactly one done pulse observed.
REQ-037 reset low during ACCESS of a write -> Datos Z, oe 0, busy 0 immediately (no clock), no done, LEDs unchanged.
REQ-038 WAIT_CYCLES=1 read of SRAM addr 16'h0010 -> done at accept+3 edges, rdata equals bus model data.
